// File: rtl/memory_access.sv
// MEM stage of the 5-stage pipeline: 64x32 data memory plus the MEM/WB pipeline register.
// Optional misaligned LW/SW detection is built when MEM_ACCESS_ALIGN_CHECK_EN is defined.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_IR,
    input  logic [31:0] EX_MEM_ALU_output,
    input  logic [31:0] EX_MEM_B,
    input  logic        EX_MEM_valid,
    input  logic        stall,
    output logic [31:0] MEM_WB_IR,
    output logic [31:0] MEM_WB_ALU_output,
    output logic [31:0] MEM_WB_LMD,
    output logic        MEM_WB_valid,
    output logic        MEM_WB_misalign
);
    localparam int MEM_WORDS = 64;
    localparam logic [5:0] OP_LW   = 6'b001000;
    localparam logic [5:0] OP_SW   = 6'b001001;
    localparam logic [5:0] OP_BEQZ = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b001011;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic        valid;
        logic        misalign;
    } mem_wb_t;

    logic [31:0] mem [MEM_WORDS];
    mem_wb_t     wb_q;
    mem_wb_t     wb_d;
    logic [5:0]  opcode;
    logic [5:0]  idx;
    logic        is_lw;
    logic        is_sw;
    logic        misalign;
    logic        wr_en;
    logic [31:0] rd_data;

    assign opcode = EX_MEM_IR[31:26];
    // Bits [31:8] are dropped, so byte addresses wrap every 256 bytes.
    assign idx    = EX_MEM_ALU_output[7:2];
    assign is_lw  = EX_MEM_valid && (opcode == OP_LW);
    assign is_sw  = EX_MEM_valid && (opcode == OP_SW);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign misalign = (is_lw || is_sw) && (EX_MEM_ALU_output[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Combinational read sees the old word, so a same-edge write never bypasses into LMD.
    assign rd_data = mem[idx];
    assign wr_en   = !rst && !stall && is_sw && !misalign;

    always_comb begin
        wb_d = '0;
        if (EX_MEM_valid) begin
            wb_d.ir       = EX_MEM_IR;
            wb_d.alu      = EX_MEM_ALU_output;
            wb_d.valid    = 1'b1;
            wb_d.misalign = misalign;
            if (is_lw && !misalign) begin
                wb_d.lmd = rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q <= '0;
        end else if (!stall) begin
            wb_q <= wb_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= EX_MEM_B;
        end
    end

    assign MEM_WB_IR         = wb_q.ir;
    assign MEM_WB_ALU_output = wb_q.alu;
    assign MEM_WB_LMD        = wb_q.lmd;
    assign MEM_WB_valid      = wb_q.valid;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign MEM_WB_misalign   = wb_q.misalign;
`else
    assign MEM_WB_misalign   = 1'b0;
`endif

    // Opcodes other than LW/SW fall through as plain pass-through slots.
    logic unused_ok;
    assign unused_ok = ^{OP_BEQZ, OP_J};
endmodule
